// File: rtl/uart_line_rx_pkg.sv
// Shared byte constants, state encoding and byte classifiers for the UART line receiver.
package uart_line_rx_pkg;

  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_BS  = 8'h08;
  localparam logic [7:0] CH_DEL = 8'h7F;

  typedef enum logic [0:0] {
    StCollect = 1'b0,
    StHold    = 1'b1
  } state_e;

  function automatic logic is_eol(input logic [7:0] b);
    return (b == CH_CR) || (b == CH_LF);
  endfunction

  function automatic logic is_erase(input logic [7:0] b);
    return (b == CH_BS) || (b == CH_DEL);
  endfunction

endpackage

// File: rtl/uart_line_rx_line_ram.sv
// Line buffer: DEPTH x 8, synchronous write, asynchronous (show-ahead) read.
module line_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_line_rx.sv
// Collects UART bytes into a line with backspace editing, then holds the line for byte-wise readout.
module uart_line_rx
  import uart_line_rx_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk_50m,
  input  logic          rst,
  input  logic          rx_rdy,
  input  logic [7:0]    rx_data,
  output logic          line_rdy,
  output logic [AW:0]   line_len,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          line_ovf,
  output logic          rx_lost
);

  localparam logic [AW:0] Full = (AW + 1)'(DEPTH);

  state_e        state_q, state_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic          ovf_q, ovf_d;
  logic          rx_rdy_q;
  logic          byte_ev;
  logic          we;

  assign byte_ev = rx_rdy & ~rx_rdy_q;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    we       = 1'b0;
    unique case (state_q)
      StCollect: begin
        if (byte_ev) begin
          if (is_eol(rx_data)) begin
            // Empty lines (and the LF of CRLF) are swallowed
            if (count_q != '0) begin
              state_d  = StHold;
              rd_ptr_d = '0;
            end
          end else if (is_erase(rx_data)) begin
            if (count_q != '0) begin
              count_d = count_q - 1'b1;
            end
          end else if (count_q < Full) begin
            we      = 1'b1;
            count_d = count_q + 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      StHold: begin
        if (rd_en) begin
          if ({1'b0, rd_ptr_q} == count_q - 1'b1) begin
            state_d  = StCollect;
            count_d  = '0;
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
        end
      end
      default: state_d = StCollect;
    endcase
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state_q  <= StCollect;
      count_q  <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      rx_rdy_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      rx_rdy_q <= rx_rdy;
    end
  end

  line_ram #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_line_ram (
    .clk  (clk_50m),
    .we   (we & ~rst),
    .waddr(count_q[AW-1:0]),
    .wdata(rx_data),
    .raddr(rd_ptr_q),
    .rdata(rd_data)
  );

  assign line_rdy = (state_q == StHold);
  assign line_len = count_q;
  assign line_ovf = ovf_q;
  assign rx_lost  = byte_ev & (state_q == StHold);

endmodule

// File: doc/uart_line_rx.md
UART_LINE_RX -- requirements
Module: uart_line_rx

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning line buffer capacity in bytes (power of two, 2..256).
REQ-002 SHALL have parameter AW, default 4, meaning log2(DEPTH), the read/write pointer width.
REQ-003 SHALL have port clk_50m, input, width 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, width 1: reset, synchronous and active-high.
REQ-005 SHALL have port rx_rdy, input, width 1: byte-available level from the UART receiver.
REQ-006 SHALL have port rx_data, input, width 8: received byte, valid while rx_rdy is high.
REQ-007 SHALL have port line_rdy, output, width 1: a complete line is held and readable.
REQ-008 SHALL have port line_len, output, width AW+1: number of stored bytes in the current line (0..DEPTH).
REQ-009 SHALL have port rd_en, input, width 1: pops one byte when line_rdy is high.
REQ-010 SHALL have port rd_data, output, width 8: byte at the read pointer (show-ahead).
REQ-011 SHALL have port line_ovf, output, width 1: the held or collecting line exceeded DEPTH and excess bytes were discarded.
REQ-012 SHALL have port rx_lost, output, width 1: one-cycle pulse per byte dropped because a line was pending.

Function
REQ-013 SHALL register rx_rdy into rx_rdy_q each cycle; a byte event SHALL be rx_rdy & ~rx_rdy_q, consuming rx_data that same cycle.
REQ-014 SHALL implement two states: COLLECT (line_rdy=0) and HOLD (line_rdy=1).
REQ-015 In COLLECT, for a byte event with an ordinary byte: if count<DEPTH, SHALL write it to buf[count] and increment count; otherwise SHALL discard it and set line_ovf.
REQ-016 In COLLECT, for byte 0x08 or 0x7F: SHALL decrement count if count>0, else ignore; it is never stored, and line_ovf is unchanged.
REQ-017 In COLLECT, for byte 0x0D or 0x0A: if count==0, SHALL ignore it, so CRLF yields one line and blank lines are skipped; otherwise SHALL enter HOLD next cycle with rd_ptr=0.
REQ-018 line_len SHALL equal count in both states; it SHALL be frozen in HOLD.
REQ-019 In HOLD, rd_data SHALL equal buf[rd_ptr] combinationally; rd_en SHALL advance rd_ptr by one.
REQ-020 rd_en on the byte at rd_ptr==count-1 SHALL return the block to COLLECT next cycle with count=0, rd_ptr=0, and line_ovf cleared.
REQ-021 rd_en in COLLECT SHALL be ignored; rd_data is don't-care there.
REQ-022 A byte event in HOLD, including the cycle of the final pop, SHALL be dropped and SHALL produce rx_lost=1 for exactly that cycle.
REQ-023 Count arithmetic SHALL use AW+1 bits so that count==DEPTH is representable; pointers SHALL never wrap.

Reset
REQ-024 rst SHALL set state=COLLECT, count=0, rd_ptr=0, and rx_rdy_q=0, with outputs line_rdy=0, line_len=0, line_ovf=0, and rx_lost=0.
REQ-025 Buffer contents SHALL NOT be reset.
REQ-026 rst asserted mid-line or in HOLD SHALL discard the line; a rx_rdy level held high across reset release SHALL count as one byte event.

Structure
REQ-027 Byte constants SHALL live in a shared package: CH_CR=0x0D, CH_LF=0x0A, CH_BS=0x08, and CH_DEL=0x7F.
REQ-028 The state encoding SHALL live in that same shared package.
REQ-029 The buffer SHALL be a sub-module line_ram: DEPTH x 8, one synchronous write port, one asynchronous read port.
REQ-030 All control logic SHALL reside in uart_line_rx.

Verification
REQ-031 Bytes "Hi\r\n" -> line_rdy=1 with line_len=2; rd_data="H", then after rd_en "i"; the second rd_en -> line_rdy=0 next cycle, and the '\n' produces no empty line.
REQ-032 "ab", 0x08, "c\r" -> line_len=2 with contents "ac"; 0x08 as the first byte -> ignored, count stays 0.
REQ-033 20 bytes "0".."9","A".."J" then "\r" with DEPTH=16 -> line_len=16, contents "0".."F", and line_ovf=1 until the last pop.
REQ-034 "x" sent while a line is held, including on the final-pop cycle -> exactly one rx_lost pulse each, and the next line starts empty.
REQ-035 rx_rdy held high for 10 cycles -> exactly one byte stored.
REQ-036 rst asserted in HOLD -> next cycle line_rdy=0 and line_len=0; "Z\r" afterwards -> line "Z", line_len=1.
